// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, element encodings and letter sizing.
// Reused by the character-lookup stage downstream.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARK    = 2'd1,
        SPACE   = 2'd2,
        DISCARD = 2'd3
    } state_e;

    localparam logic EL_DOT  = 1'b0;
    localparam logic EL_DASH = 1'b1;

    localparam int MAX_ELEMS = 5;
    localparam int SYM_LEN_W = 3;

endpackage

// File: rtl/morse_run_counter.sv
// Saturating run-length counter with clear-to-0, clear-to-1 and increment,
// plus a registered-count threshold compare (cnt >= THRESH).
module morse_run_counter #(
    parameter int CNT_W  = 8,
    parameter int THRESH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr_zero_i,
    input  logic             clr_one_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hit_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_zero_i) begin
            cnt_d = '0;
        end else if (clr_one_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_q >= THR);

endmodule

// File: rtl/morse_letter_assembler.sv
// Classifies keyed marks as dot/dash, detects inter-letter gaps and packs up
// to MAX_ELEMS elements into a letter offered through a one-entry valid/ready buffer.
module morse_letter_assembler
    import morse_pkg::*;
#(
    parameter int DASH_LEN = 3,
    parameter int GAP_LEN  = 3,
    parameter int CNT_W    = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 I,
    input  logic                 dot,
    input  logic                 sym_ready,
    output logic                 sym_valid,
    output logic [SYM_LEN_W-1:0] sym_len,
    output logic [MAX_ELEMS-1:0] sym_bits,
    output logic                 err,
    output logic                 overrun
);

    // Handshake: a letter transfers on any rising edge where sym_valid and
    // sym_ready are both high; sym_len/sym_bits hold steady while sym_valid is
    // high and unaccepted, and sym_ready is don't-care while sym_valid is low.

    state_e               state_q;
    logic [MAX_ELEMS-1:0] elems_q;
    logic [SYM_LEN_W-1:0] elem_cnt_q;
    logic                 sym_valid_q;
    logic [SYM_LEN_W-1:0] sym_len_q;
    logic [MAX_ELEMS-1:0] sym_bits_q;
    logic                 err_q;
    logic                 overrun_q;

    logic [CNT_W-1:0] mark_cnt;
    logic [CNT_W-1:0] gap_cnt_unused;
    logic             mark_long;
    logic             gap_done;
    logic             mark_one, mark_inc;
    logic             gap_zero, gap_one, gap_inc;
    logic             is_dot_el, is_dash_el, can_load;
    logic             el;

    always_comb begin
        mark_one = ((state_q == IDLE) || (state_q == SPACE)) && I;
        mark_inc = (state_q == MARK) && I;
        gap_one  = (state_q == MARK) && !I;
        gap_zero = ((state_q == SPACE) || (state_q == DISCARD)) && I;
        gap_inc  = ((state_q == SPACE) || (state_q == DISCARD)) && !I;
    end

    morse_run_counter #(.CNT_W(CNT_W), .THRESH(DASH_LEN)) u_mark_cnt (
        .CLK        (CLK),
        .RESET      (RESET),
        .clr_zero_i (1'b0),
        .clr_one_i  (mark_one),
        .inc_i      (mark_inc),
        .cnt_o      (mark_cnt),
        .hit_o      (mark_long)
    );

    // The gap hit fires on the cycle whose low sample is the GAP_LEN-th one.
    morse_run_counter #(.CNT_W(CNT_W), .THRESH(GAP_LEN - 1)) u_gap_cnt (
        .CLK        (CLK),
        .RESET      (RESET),
        .clr_zero_i (gap_zero),
        .clr_one_i  (gap_one),
        .inc_i      (gap_inc),
        .cnt_o      (gap_cnt_unused),
        .hit_o      (gap_done)
    );

    assign is_dot_el  = (mark_cnt == CNT_W'(1)) && dot;
    assign is_dash_el = mark_long && !dot;
    assign el         = is_dash_el ? EL_DASH : EL_DOT;
    assign can_load   = !sym_valid_q || sym_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            elems_q     <= '0;
            elem_cnt_q  <= '0;
            sym_valid_q <= 1'b0;
            sym_len_q   <= '0;
            sym_bits_q  <= '0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            if (sym_valid_q && sym_ready) begin
                sym_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (dot) err_q <= 1'b1;
                    if (I) state_q <= MARK;
                end
                MARK: begin
                    if (!I) begin
                        if (!(is_dot_el || is_dash_el) ||
                            (elem_cnt_q == SYM_LEN_W'(MAX_ELEMS))) begin
                            err_q   <= 1'b1;
                            state_q <= DISCARD;
                        end else begin
                            elems_q    <= elems_q | (MAX_ELEMS'(el) << elem_cnt_q);
                            elem_cnt_q <= elem_cnt_q + 1'b1;
                            state_q    <= SPACE;
                        end
                    end
                end
                SPACE: begin
                    if (dot) begin
                        err_q <= 1'b1;
                        if (!I && gap_done) begin
                            state_q    <= IDLE;
                            elems_q    <= '0;
                            elem_cnt_q <= '0;
                        end else begin
                            state_q <= DISCARD;
                        end
                    end else if (I) begin
                        state_q <= MARK;
                    end else if (gap_done) begin
                        state_q    <= IDLE;
                        elems_q    <= '0;
                        elem_cnt_q <= '0;
                        if (can_load) begin
                            sym_valid_q <= 1'b1;
                            sym_len_q   <= elem_cnt_q;
                            sym_bits_q  <= elems_q;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (dot) err_q <= 1'b1;
                    if (!I && gap_done) begin
                        state_q    <= IDLE;
                        elems_q    <= '0;
                        elem_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_len   = sym_len_q;
    assign sym_bits  = sym_bits_q;
    assign err       = err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/morse_letter_assembler.md
Name: morse_letter_assembler

Overview:
- Downstream of the single-cycle-mark (dot) detector.
- Watches the same keyed line I and consumes the detector's dot pulse; classifies each mark as dot or dash and detects inter-letter gaps.
- Packs up to 5 elements into one letter code and offers it on a valid/ready output with a one-entry holding register.
- Feeds the character-lookup stage.

Parameters:
- DASH_LEN, 3: minimum mark length in cycles classified as dash.
- GAP_LEN, 3: consecutive low cycles that terminate a letter; must be ≥2.
- CNT_W, 8: width of the mark and gap run counters; saturating.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- I  input  1  keyed line, the same signal the dot detector samples.
- dot  input  1  dot detector's pulse; high in the first low cycle after a 1-cycle mark.
- sym_ready  input  1  consumer accepts the letter.
- sym_valid  output  1  letter available.
- sym_len  output  3  element count, 1..5.
- sym_bits  output  5  element k at bit k (first element bit 0); 0=dot, 1=dash; bits ≥ sym_len are 0.
- err  output  1  one-cycle pulse: malformed letter discarded.
- overrun  output  1  one-cycle pulse: completed letter dropped because the buffer was full.

Behaviour:
- Reset (async, RESET=1): state IDLE; counters 0; element shift register 0; sym_valid=0, sym_len=0, sym_bits=0, err=0, overrun=0.
- Releasing RESET mid-mark: the line is treated as fresh. If I=1, MARK is entered with count 1 on the first clock.
- States: IDLE, MARK, SPACE, DISCARD.
- IDLE:
  - I=1 → MARK with mark_cnt=1.
  - dot=1 in IDLE → err pulse.
- MARK, I=1: mark_cnt+1, saturating at 2^CNT_W-1.
- MARK, I=0 (falling cycle) — classify, then go to SPACE with gap_cnt=1:
  - mark_cnt=1 and dot=1 → append dot.
  - mark_cnt ≥ DASH_LEN and dot=0 → append dash.
  - Anything else (length 2..DASH_LEN-1, or dot disagreeing with the count) → err pulse; go to DISCARD with gap_cnt=1.
  - Appending a 6th element → err pulse; go to DISCARD.
- SPACE:
  - I=1 → MARK, mark_cnt=1.
  - I=0 → gap_cnt+1.
  - In the cycle gap_cnt reaches GAP_LEN, the letter completes and the state returns to IDLE.
- DISCARD:
  - Any I=1 restarts the gap count at 0.
  - After GAP_LEN consecutive low cycles: clear the element register; go to IDLE with no output.
- Letter completion:
  - If the holding register is empty, or sym_valid & sym_ready in the same cycle, load sym_len/sym_bits.
  - sym_valid=1 from the next cycle.
  - Otherwise drop the letter and pulse overrun on the next cycle; the held letter is unchanged.
- Handshake:
  - sym_valid stays high, and sym_len/sym_bits stay stable, until a cycle with sym_ready=1; sym_valid deasserts the following cycle unless a load occurs in that same cycle.
  - sym_ready is ignored when sym_valid=0.
- Latency: sym_valid is high exactly one cycle after the GAP_LEN-th low cycle.
- dot asserted while in SPACE or DISCARD → err pulse. In SPACE the partial letter is discarded (go to DISCARD).
- err and overrun may pulse in the same cycle; each is at most one cycle per event.

Decomposition:
- Shared package morse_pkg:
  - state enum {IDLE, MARK, SPACE, DISCARD};
  - element encodings EL_DOT=0, EL_DASH=1;
  - MAX_ELEMS=5, SYM_LEN_W=3.
  - This package is reused by the lookup stage.
- Sub-module morse_run_counter: saturating CNT_W counter with clear-to-1 / increment / threshold-compare; instantiated twice, for mark and gap.

Test Plan (default parameters, sym_ready=1 unless stated):
- Letter A: I=1×1, 0×1, 1×3, 0×3, dot driven per the detector → one sym_valid one cycle after the 3rd low, sym_len=2, sym_bits=5'b00010, err=0.
- Mark of length 2 followed by 3 low cycles → err pulses once at the falling cycle; no sym_valid.
- Six dots (1 high/1 low each), then 3 low cycles → err on the 6th element; no symbol. The next letter E (a single dot) decodes as sym_len=1, sym_bits=0.
- Backpressure: sym_ready=0, send E then T → E held stable (len=1, bits=0); overrun pulses once after T completes. Raise sym_ready → sym_valid drops one cycle later.
- dot=1 while I has been low for 2 cycles (SPACE) → err pulse; the partial letter is discarded.
- RESET asserted during the 2nd cycle of a dash → all outputs 0 immediately. A clean E afterwards decodes as len=1, bits=0.
